// File: rtl/processor_sequencer.sv
// Multi-cycle control sequencer for the 8-register + ISR processor datapath.
// Accepts instruction/immediate bytes over valid/ack and drives datapath strobes one micro-step per clock.
module processor_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ack,
  output logic       ir_in,
  output logic [7:0] reg_in,
  output logic [3:0] bus_sel,
  output logic       a_in,
  output logic       g_in,
  output logic       alu_sub,
  output logic       isr_shift,
  output logic       busy,
  output logic       done,
  output logic [3:0] currstate
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    DECODE = 4'd1,
    MV     = 4'd2,
    IMM_HI = 4'd3,
    IMM_LO = 4'd4,
    IMM_WR = 4'd5,
    ALU_A  = 4'd6,
    ALU_G  = 4'd7,
    ALU_WR = 4'd8,
    DONE   = 4'd9
  } state_t;

  state_t     state, next_state;
  logic [1:0] opcode;
  logic [2:0] rx, ry;
  logic       take;

  // Reset wins over a pending byte, so no handshake is offered while it is high.
  assign take = instr_valid && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      opcode <= '0;
      rx     <= '0;
      ry     <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && instr_valid) begin
        opcode <= instr[7:6];
        rx     <= instr[5:3];
        ry     <= instr[2:0];
      end
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = instr_valid ? DECODE : IDLE;
      DECODE: begin
        case (opcode)
          2'b00:   next_state = MV;
          2'b01:   next_state = IMM_HI;
          default: next_state = ALU_A;
        endcase
      end
      MV:      next_state = DONE;
      IMM_HI:  next_state = instr_valid ? IMM_LO : IMM_HI;
      IMM_LO:  next_state = instr_valid ? IMM_WR : IMM_LO;
      IMM_WR:  next_state = DONE;
      ALU_A:   next_state = ALU_G;
      ALU_G:   next_state = ALU_WR;
      ALU_WR:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    instr_ack = 1'b0;
    ir_in     = 1'b0;
    reg_in    = '0;
    bus_sel   = '0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    alu_sub   = 1'b0;
    isr_shift = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        instr_ack = take;
        ir_in     = take;
      end
      MV: begin
        bus_sel = {1'b0, ry};
        reg_in  = 8'd1 << rx;
      end
      IMM_HI, IMM_LO: begin
        instr_ack = take;
        isr_shift = take;
      end
      IMM_WR: begin
        bus_sel = 4'd9;
        reg_in  = 8'd1 << rx;
      end
      ALU_A: begin
        bus_sel = {1'b0, rx};
        a_in    = 1'b1;
      end
      ALU_G: begin
        bus_sel = {1'b0, ry};
        g_in    = 1'b1;
        alu_sub = opcode[0];
      end
      ALU_WR: begin
        bus_sel = 4'd8;
        reg_in  = 8'd1 << rx;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    busy      = (state != IDLE);
    currstate = state;
  end

endmodule

// File: tb/tb_processor_sequencer.sv
// Bench for processor_sequencer: expected per-cycle traces built from instruction semantics,
// plus a datapath model driven by the strobes whose register file is checked against plain arithmetic.
module tb_processor_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ack, ir_in, a_in, g_in, alu_sub, isr_shift, busy, done;
  logic [7:0] reg_in;
  logic [3:0] bus_sel, currstate;

  processor_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ack   (instr_ack),
    .ir_in       (ir_in),
    .reg_in      (reg_in),
    .bus_sel     (bus_sel),
    .a_in        (a_in),
    .g_in        (g_in),
    .alu_sub     (alu_sub),
    .isr_shift   (isr_shift),
    .busy        (busy),
    .done        (done),
    .currstate   (currstate)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ack;
    logic       ir;
    logic [7:0] reg_in;
    logic [3:0] bus;
    logic       a;
    logic       g;
    logic       sub;
    logic       isr;
    logic       busy;
    logic       done;
    logic [3:0] st;
  } obs_t;

  int unsigned tests = 0;
  int unsigned failed = 0;

  // Datapath model driven by the DUT strobes.
  logic [15:0] rf [8];
  logic [15:0] isr_m, a_m, g_m;

  logic       hold = 1'b0;
  logic [7:0] hold_byte = '0;

  function automatic obs_t base(input logic [3:0] st);
    obs_t x;
    x      = '0;
    x.st   = st;
    x.busy = (st != 4'd0);
    return x;
  endfunction

  task automatic noise(output logic v, output logic [7:0] b);
    if (hold) begin
      v = 1'b1;
      b = hold_byte;
    end else begin
      v = 1'($urandom_range(0, 1));
      b = 8'($urandom);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input obs_t exp, input string tag);
    obs_t        obs;
    logic [15:0] busv;
    instr_valid = v;
    instr       = b;
    #3;
    obs = {instr_ack, ir_in, reg_in, bus_sel, a_in, g_in, alu_sub, isr_shift, busy, done, currstate};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    if (bus_sel < 4'd8) busv = rf[bus_sel[2:0]];
    else if (bus_sel == 4'd8) busv = g_m;
    else busv = isr_m;
    if (g_in) g_m = alu_sub ? a_m - busv : a_m + busv;
    if (a_in) a_m = busv;
    for (int i = 0; i < 8; i++) if (reg_in[i]) rf[i] = busv;
    if (isr_shift) isr_m = {isr_m[7:0], instr};
    @(posedge clock);
    #1;
  endtask

  task automatic check_rf(input logic [15:0] exp [8], input string tag);
    tests++;
    assert (rf == exp) else begin
      failed++;
      $error("FAIL %s: regfile R0..R7 observed=%h %h %h %h %h %h %h %h expected=%h %h %h %h %h %h %h %h",
             tag, rf[0], rf[1], rf[2], rf[3], rf[4], rf[5], rf[6], rf[7],
             exp[0], exp[1], exp[2], exp[3], exp[4], exp[5], exp[6], exp[7]);
    end
  endtask

  task automatic run_instr(input logic [7:0] ins, input logic [7:0] hi, input logic [7:0] lo,
                           input int unsigned whi, input int unsigned wlo, input string tag);
    obs_t        x;
    logic        v;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [2:0]  rx, ry;
    logic [15:0] exp_rf [8];
    op = ins[7:6];
    rx = ins[5:3];
    ry = ins[2:0];
    exp_rf = rf;
    x = base(4'd0); x.ack = 1'b1; x.ir = 1'b1;
    cyc(1'b1, ins, x, {tag, "_accept"});
    noise(v, b);
    cyc(v, b, base(4'd1), {tag, "_decode"});
    case (op)
      2'b00: begin
        x = base(4'd2); x.bus = {1'b0, ry}; x.reg_in = 8'd1 << rx;
        noise(v, b);
        cyc(v, b, x, {tag, "_mv"});
        exp_rf[rx] = rf[ry];
      end
      2'b01: begin
        for (int unsigned i = 0; i < whi; i++) cyc(1'b0, 8'($urandom), base(4'd3), {tag, "_hi_wait"});
        x = base(4'd3); x.ack = 1'b1; x.isr = 1'b1;
        cyc(1'b1, hi, x, {tag, "_hi"});
        for (int unsigned i = 0; i < wlo; i++) cyc(1'b0, 8'($urandom), base(4'd4), {tag, "_lo_wait"});
        x = base(4'd4); x.ack = 1'b1; x.isr = 1'b1;
        cyc(1'b1, lo, x, {tag, "_lo"});
        x = base(4'd5); x.bus = 4'd9; x.reg_in = 8'd1 << rx;
        noise(v, b);
        cyc(v, b, x, {tag, "_imm_wr"});
        exp_rf[rx] = {hi, lo};
      end
      default: begin
        x = base(4'd6); x.bus = {1'b0, rx}; x.a = 1'b1;
        noise(v, b);
        cyc(v, b, x, {tag, "_alu_a"});
        x = base(4'd7); x.bus = {1'b0, ry}; x.g = 1'b1; x.sub = op[0];
        noise(v, b);
        cyc(v, b, x, {tag, "_alu_g"});
        x = base(4'd8); x.bus = 4'd8; x.reg_in = 8'd1 << rx;
        noise(v, b);
        cyc(v, b, x, {tag, "_alu_wr"});
        exp_rf[rx] = op[0] ? exp_rf[rx] - exp_rf[ry] : exp_rf[rx] + exp_rf[ry];
      end
    endcase
    x = base(4'd9); x.done = 1'b1;
    noise(v, b);
    cyc(v, b, x, {tag, "_done"});
    check_rf(exp_rf, {tag, "_result"});
  endtask

  initial begin
    obs_t        x;
    logic [15:0] snap [8];
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    isr_m = '0; a_m = '0; g_m = '0;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    @(posedge clock);
    #1;
    cyc(1'b1, 8'h15, base(4'd0), "reset_overrides_valid");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, base(4'd0), "idle");

    run_instr(8'h15, 8'h00, 8'h00, 0, 0, "mv_r2_r5");
    cyc(1'b0, 8'h00, base(4'd0), "gap0");
    cyc(1'b0, 8'h00, base(4'd0), "gap1");
    run_instr(8'h78, 8'hAB, 8'hCD, 2, 0, "mvi_r7");
    run_instr(8'hCB, 8'h00, 8'h00, 0, 0, "sub_r1_r3");
    run_instr(8'hA4, 8'h00, 8'h00, 0, 0, "add_r4_r4");
    run_instr(8'h12, 8'h00, 8'h00, 0, 0, "mv_r2_r2");

    // Reset in ALU_G of add R0,R1, with a mv R6,R0 held pending through reset.
    snap = rf;
    x = base(4'd0); x.ack = 1'b1; x.ir = 1'b1;
    cyc(1'b1, 8'h81, x, "abort_accept");
    cyc(1'b0, 8'h00, base(4'd1), "abort_decode");
    x = base(4'd6); x.bus = 4'd0; x.a = 1'b1;
    cyc(1'b0, 8'h00, x, "abort_alu_a");
    reset = 1'b1;
    x = base(4'd7); x.bus = 4'd1; x.g = 1'b1;
    cyc(1'b1, 8'h30, x, "abort_in_reset");
    cyc(1'b1, 8'h30, base(4'd0), "abort_reset_held");
    reset = 1'b0;
    check_rf(snap, "abort_no_write");
    run_instr(8'h30, 8'h00, 8'h00, 0, 0, "after_reset_mv");

    // Back-to-back mv with valid held: next accept directly follows done.
    hold = 1'b1; hold_byte = 8'h0B;
    run_instr(8'h0B, 8'h00, 8'h00, 0, 0, "b2b_first");
    run_instr(8'h0B, 8'h00, 8'h00, 0, 0, "b2b_second");
    hold = 1'b0;

    for (int i = 0; i < 40; i++) begin
      run_instr(8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), "random");
      if ($urandom_range(0, 1) == 1) cyc(1'b0, 8'h00, base(4'd0), "random_gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/processor_sequencer.md
Name: processor_sequencer

Overview:
- Multi-cycle control FSM for the 8-register (R0..R7) + ISR processor datapath.
- Accepts 8-bit instruction/data bytes over a valid/ack handshake and decodes them.
- Sequences the register-file load enables, the shared-bus mux select, the A/G/ISR load strobes and the ALU add/sub control, one micro-step per clock.
- Exposes its state on currstate for board debug.

Parameters:
- None. The register count (8), byte width (8) and state width (4) are fixed by the instruction format.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instr holds a valid byte; held until instr_ack.
- instr  in  8  instruction byte: [7:6]=opcode, [5:3]=rx, [2:0]=ry; immediate data byte in IMM states.
- instr_ack  out  1  one-cycle pulse; the byte on instr is consumed this cycle.
- ir_in  out  1  load datapath instruction register.
- reg_in  out  8  one-hot register write enable, bit n = Rn.
- bus_sel  out  4  bus source: 0-7 = R0-R7, 8 = G, 9 = ISR.
- a_in  out  1  load A from bus.
- g_in  out  1  load G with the ALU result (A ± bus).
- alu_sub  out  1  0 = add, 1 = subtract.
- isr_shift  out  1  ISR <= {ISR[7:0], instr}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at instruction completion.
- currstate  out  4  current state encoding.

Behaviour:
- Opcodes:
  - 00 mv Rx<-Ry
  - 01 mvi Rx<-16-bit immediate (two following bytes, high byte first)
  - 10 add Rx<-Rx+Ry
  - 11 sub Rx<-Rx-Ry
- State encodings: IDLE=0, DECODE=1, MV=2, IMM_HI=3, IMM_LO=4, IMM_WR=5, ALU_A=6, ALU_G=7, ALU_WR=8, DONE=9. Codes 10-15 are unused and go to IDLE on the next clock with all strobes low.
- Outputs are Moore, decoded from state plus the internally latched opcode/rx/ry. Exception: instr_ack, ir_in and isr_shift also require instr_valid. Any strobe not listed for a state is 0; bus_sel defaults to 0.
- IDLE:
  - With instr_valid: instr_ack=1, ir_in=1, latch opcode/rx/ry, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE: no strobes. Go to MV, IMM_HI or ALU_A by opcode.
- MV: bus_sel=ry, reg_in[rx]=1, then DONE.
- IMM_HI: wait for instr_valid; when high, instr_ack=1, isr_shift=1, go to IMM_LO.
- IMM_LO: same as IMM_HI, then go to IMM_WR.
- IMM_WR: bus_sel=9, reg_in[rx]=1, then DONE.
- ALU_A: bus_sel=rx, a_in=1, then ALU_G.
- ALU_G: bus_sel=ry, g_in=1, alu_sub=opcode[0], then ALU_WR.
- ALU_WR: bus_sel=8, reg_in[rx]=1, then DONE.
- DONE: done=1, then IDLE. A new instruction is accepted no earlier than the cycle after DONE.
- Latency, counted from the accept cycle T to the done pulse:
  - mv: done at T+3.
  - add/sub: done at T+5.
  - mvi: done at T+5 plus the wait cycles spent in IMM_HI/IMM_LO.
- instr_valid outside IDLE/IMM_HI/IMM_LO is ignored: no ack, no strobe, byte left pending.
- rx==ry is legal: add R3,R3 doubles R3; mv R2,R2 is a no-op write.
- reg_in is one-hot or zero in every cycle; at most one of a_in/g_in/reg_in≠0 per cycle; bus_sel is always ≤ 9.
- Reset:
  - Synchronous. At the next rising edge: state=IDLE, latched fields=0, every output 0 (currstate=0, busy=0).
  - Reset overrides instr_valid in the same cycle.
  - Reset mid-instruction aborts it with no further reg_in pulse.
- No pipelining: exactly one instruction in flight.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, currstate=0, no instr_ack.
- instr=8'b00_010_101 (mv R2,R5) valid at T -> instr_ack+ir_in at T; at T+2 bus_sel=5, reg_in=8'h04; done at T+3; currstate sequence 0,1,2,9,0.
- mvi R7: bytes 8'h78, 8'hAB, 8'hCD, with valid dropped 2 cycles before the high byte -> isr_shift exactly twice, with acks on the AB and CD cycles only; IMM_WR has bus_sel=9, reg_in=8'h80; done pulses once.
- sub R1,R3 (8'b11_001_011) -> ALU_A bus_sel=1 a_in; ALU_G bus_sel=3 g_in alu_sub=1; ALU_WR bus_sel=8 reg_in=8'h02; done at T+5. Repeat as add R4,R4 (8'h A4) -> alu_sub=0, bus_sel 4/4/8, reg_in=8'h10.
- Reset asserted in ALU_G of add R0,R1 -> next cycle state IDLE, no reg_in pulse, no done; instr_valid held through reset is accepted only after reset deasserts.
- Back-to-back mv instructions with instr_valid held high -> second instr_ack one cycle after the first done; instr_ack never asserted while in DECODE, MV or DONE.
